// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with an iterative RV32M multiply/divide path.
// Decodes alu_op/funct3/funct7 into a control code, runs single-cycle ops with a
// registered result one cycle after acceptance, and runs MUL*/DIV*/REM* on a
// shift-add / restoring-divide datapath under a valid/ready handshake.
// Ports:
//   clk, rst_n (synchronous, active-low)   in_valid/in_ready  request handshake
//   kill      abort in-flight op / block acceptance this cycle
//   alu_op, opb_5, funct3, funct7_5, funct7_0   instruction decode fields
//   src_a, src_b   operands (sampled only at the accept edge)
//   alu_ctrl  combinational decoded control code of the current inputs
//   out_valid one-cycle result pulse; result/zero/illegal held until the next pulse
module alu_exec_unit #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              kill,
    input  logic [1:0]        alu_op,
    input  logic              opb_5,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic              funct7_0,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              out_valid,
    output logic [XLEN-1:0]   result,
    output logic              zero,
    output logic              illegal
);
    localparam int SHW   = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [3:0] C_ADD    = 4'b0000;
    localparam logic [3:0] C_SUB    = 4'b0001;
    localparam logic [3:0] C_AND    = 4'b0010;
    localparam logic [3:0] C_OR     = 4'b0011;
    localparam logic [3:0] C_XOR    = 4'b0100;
    localparam logic [3:0] C_SLT    = 4'b0101;
    localparam logic [3:0] C_SLL    = 4'b0110;
    localparam logic [3:0] C_SRL    = 4'b0111;
    localparam logic [3:0] C_SRA    = 4'b1000;
    localparam logic [3:0] C_SLTU   = 4'b1001;
    localparam logic [3:0] C_MULDIV = 4'b1111;

    localparam logic [XLEN-1:0] X_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] X_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] X_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_ITER = 2'b01, ST_FIX = 2'b10} state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       f3_r;
    logic             neg_r;
    logic [XLEN-1:0]  hi_r, lo_r, mag_r;
    logic             out_valid_r, zero_r, illegal_r;
    logic [XLEN-1:0]  result_r;

    logic [3:0]       ctrl_s;
    logic             is_illegal_s, is_md_s, is_div_s, sgn_a_s, sgn_b_s, a_neg_s, b_neg_s;
    logic             div_zero_s, div_ovf_s, special_s;
    logic [XLEN-1:0]  a_mag_s, b_mag_s, sc_res_s, acc_res_s, fix_res_s;
    logic [SHW-1:0]   shamt_s;
    logic [XLEN:0]    mul_sum_s, div_shift_s, div_diff_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;

    assign in_ready  = (state_r == ST_IDLE) && !kill;
    assign alu_ctrl  = CTRL_W'(ctrl_s);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign illegal   = illegal_r;

    // Decode instruction fields into the control code.
    always_comb begin
        ctrl_s = C_ADD;
        case (alu_op)
            2'b00: ctrl_s = C_ADD;
            2'b01: ctrl_s = C_SUB;
            2'b10: begin
                if (opb_5 && funct7_0) begin
                    ctrl_s = C_MULDIV;
                end else begin
                    case (funct3)
                        3'b000:  ctrl_s = (funct7_5 && opb_5) ? C_SUB : C_ADD;
                        3'b001:  ctrl_s = C_SLL;
                        3'b010:  ctrl_s = C_SLT;
                        3'b011:  ctrl_s = C_SLTU;
                        3'b100:  ctrl_s = C_XOR;
                        3'b101:  ctrl_s = funct7_5 ? C_SRA : C_SRL;
                        3'b110:  ctrl_s = C_OR;
                        3'b111:  ctrl_s = C_AND;
                        default: ctrl_s = C_ADD;
                    endcase
                end
            end
            default: ctrl_s = C_ADD;
        endcase
    end

    // Operand classification, magnitudes and division special cases.
    always_comb begin
        is_illegal_s = (alu_op == 2'b11);
        is_md_s      = (ctrl_s == C_MULDIV);
        is_div_s     = funct3[2];
        // div/rem are signed when funct3[0]=0; mulh signs both, mulhsu only a.
        sgn_a_s      = funct3[2] ? !funct3[0] : ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10));
        sgn_b_s      = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01);
        a_neg_s      = sgn_a_s && src_a[XLEN-1];
        b_neg_s      = sgn_b_s && src_b[XLEN-1];
        a_mag_s      = a_neg_s ? (X_ZERO - src_a) : src_a;
        b_mag_s      = b_neg_s ? (X_ZERO - src_b) : src_b;
        div_zero_s   = is_div_s && (src_b == X_ZERO);
        div_ovf_s    = is_div_s && !funct3[0] && (src_a == X_MIN) && (src_b == X_ONES);
        special_s    = is_md_s && (div_zero_s || div_ovf_s);
        shamt_s      = src_b[SHW-1:0];
    end

    // Single-cycle result and the value registered at an accept edge.
    always_comb begin
        sc_res_s = X_ZERO;
        case (ctrl_s)
            C_ADD:   sc_res_s = src_a + src_b;
            C_SUB:   sc_res_s = src_a - src_b;
            C_AND:   sc_res_s = src_a & src_b;
            C_OR:    sc_res_s = src_a | src_b;
            C_XOR:   sc_res_s = src_a ^ src_b;
            C_SLT:   sc_res_s = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            C_SLTU:  sc_res_s = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            C_SLL:   sc_res_s = src_a << shamt_s;
            C_SRL:   sc_res_s = src_a >> shamt_s;
            C_SRA:   sc_res_s = $unsigned($signed(src_a) >>> shamt_s);
            default: sc_res_s = X_ZERO;
        endcase
        if (is_illegal_s) begin
            acc_res_s = X_ZERO;
        end else if (special_s) begin
            // funct3[1] picks the remainder form.
            if (div_zero_s) begin
                acc_res_s = funct3[1] ? src_a : X_ONES;
            end else begin
                acc_res_s = funct3[1] ? X_ZERO : X_MIN;
            end
        end else begin
            acc_res_s = sc_res_s;
        end
    end

    // One iteration step of shift-add multiply / restoring divide, plus the FIX-stage result.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag_r} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, mag_r};
        prod_s      = {hi_r, lo_r};
        prod_fix_s  = neg_r ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
        if (f3_r[2]) begin
            // Divide: hi holds the remainder, lo the quotient.
            if (f3_r[1]) begin
                fix_res_s = neg_r ? (X_ZERO - hi_r) : hi_r;
            end else begin
                fix_res_s = neg_r ? (X_ZERO - lo_r) : lo_r;
            end
        end else begin
            if (f3_r[1:0] == 2'b00) begin
                fix_res_s = prod_fix_s[XLEN-1:0];
            end else begin
                fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
            end
        end
    end

    // Control FSM, iteration registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            f3_r        <= 3'b000;
            neg_r       <= 1'b0;
            hi_r        <= X_ZERO;
            lo_r        <= X_ZERO;
            mag_r       <= X_ZERO;
            out_valid_r <= 1'b0;
            result_r    <= X_ZERO;
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        if (is_md_s && !special_s && !is_illegal_s) begin
                            state_r <= ST_ITER;
                            cnt_r   <= {CNT_W{1'b0}};
                            f3_r    <= funct3;
                            // Remainder follows the dividend; quotient/product the sign xor.
                            neg_r   <= (funct3[2] && funct3[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
                            hi_r    <= X_ZERO;
                            lo_r    <= a_mag_s;
                            mag_r   <= b_mag_s;
                        end else begin
                            out_valid_r <= 1'b1;
                            result_r    <= acc_res_s;
                            zero_r      <= (acc_res_s == X_ZERO);
                            illegal_r   <= is_illegal_s;
                        end
                    end
                end
                ST_ITER: begin
                    if (kill) begin
                        state_r <= ST_IDLE;
                    end else begin
                        if (f3_r[2]) begin
                            if (!div_diff_s[XLEN]) begin
                                hi_r <= div_diff_s[XLEN-1:0];
                                lo_r <= {lo_r[XLEN-2:0], 1'b1};
                            end else begin
                                hi_r <= div_shift_s[XLEN-1:0];
                                lo_r <= {lo_r[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            hi_r <= mul_sum_s[XLEN:1];
                            lo_r <= {mul_sum_s[0], lo_r[XLEN-1:1]};
                        end
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == CNT_W'(XLEN-1)) begin
                            state_r <= ST_FIX;
                        end else begin
                            state_r <= ST_ITER;
                        end
                    end
                end
                ST_FIX: begin
                    state_r <= ST_IDLE;
                    if (!kill) begin
                        out_valid_r <= 1'b1;
                        result_r    <= fix_res_s;
                        zero_r      <= (fix_res_s == X_ZERO);
                        illegal_r   <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule
